// File: rtl/mailbox_dpram.sv
// Byte-wide mailbox between the MMC SPI configuration path (port 1) and the FPGA
// local bus (port 2): two logical ports time-share one single-port array.
module mailbox_dpram #(
  parameter int aw = 11,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [aw-1:0] addr1,
  input  logic [dw-1:0] din1,
  input  logic          wen1,
  input  logic          ren1,
  output logic [dw-1:0] dout1,
  input  logic [aw-1:0] addr2,
  input  logic [dw-1:0] din2,
  input  logic          wen2,
  input  logic          ren2,
  output logic [dw-1:0] dout2,
  output logic          error
);

  localparam int Depth = 1 << aw;

  // No reset on the array: rst must leave the mailbox contents intact, and the
  // zero power-up contents come from device configuration of the storage.
  logic [dw-1:0] mem_q [0:Depth-1];

  logic          act1;
  logic          act2;
  logic          grant2;
  logic          rd1;
  logic          rd2;
  logic          memWe;
  logic [aw-1:0] memAddr;
  logic [dw-1:0] memDin;
  logic [dw-1:0] rdWord;

  logic [dw-1:0] dout1_d, dout1_q;
  logic [dw-1:0] dout2_d, dout2_q;
  logic          error_d, error_q;

  // Port 1 always wins a contested cycle; port 2 only owns the array when port 1
  // is idle, and a write on the owning port takes precedence over its read.
  always_comb begin
    act1    = wen1 | ren1;
    act2    = wen2 | ren2;
    grant2  = act2 & ~act1;
    memAddr = act1 ? addr1 : addr2;
    memDin  = act1 ? din1 : din2;
    memWe   = act1 ? wen1 : (grant2 & wen2);
    rd1     = act1 & ren1 & ~wen1;
    rd2     = grant2 & ren2 & ~wen2;
    rdWord  = mem_q[memAddr];
  end

  // Each dout holds its last read until a successful read on the same port.
  always_comb begin
    dout1_d = dout1_q;
    dout2_d = dout2_q;
    error_d = act1 & act2;
    if (rd1) begin
      dout1_d = rdWord;
    end
    if (rd2) begin
      dout2_d = rdWord;
    end
  end

  // Writes are deliberately outside the reset branch so they land even in reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[memAddr] <= memDin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout1_q <= '0;
      dout2_q <= '0;
      error_q <= 1'b0;
    end else begin
      dout1_q <= dout1_d;
      dout2_q <= dout2_d;
      error_q <= error_d;
    end
  end

  assign dout1 = dout1_q;
  assign dout2 = dout2_q;
  assign error = error_q;

endmodule

// File: tb/tb_mailbox_dpram.sv
// Directed bench for mailbox_dpram: a behavioural mailbox model queues the
// expected outputs of every cycle, which are popped and checked after the edge.
module tb_mailbox_dpram;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] din1, din2;
  logic          wen1, ren1, wen2, ren2;
  logic [DW-1:0] dout1, dout2;
  logic          error;

  logic [DW-1:0] model [0:DEPTH-1];
  logic [DW-1:0] expDout1, expDout2;

  logic [DW-1:0] exp1Q [$];
  logic [DW-1:0] exp2Q [$];
  logic          expErrQ [$];
  string         tagQ [$];

  int testsRun = 0;
  int failCount = 0;

  mailbox_dpram #(.aw(AW), .dw(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr1(addr1),
    .din1 (din1),
    .wen1 (wen1),
    .ren1 (ren1),
    .dout1(dout1),
    .addr2(addr2),
    .din2 (din2),
    .wen2 (wen2),
    .ren2 (ren2),
    .dout2(dout2),
    .error(error)
  );

  always #5 clk = ~clk;

  // Pops one cycle's expectations and compares them against the registered outputs.
  task automatic checkOutput();
    logic [DW-1:0] e1, e2;
    logic          eErr;
    string         tag;
    e1   = exp1Q.pop_front();
    e2   = exp2Q.pop_front();
    eErr = expErrQ.pop_front();
    tag  = tagQ.pop_front();
    testsRun++;
    assert (dout1 === e1)
      else begin
        failCount++;
        $error("[TB] FAIL %s dout1: observed %h expected %h", tag, dout1, e1);
      end
    testsRun++;
    assert (dout2 === e2)
      else begin
        failCount++;
        $error("[TB] FAIL %s dout2: observed %h expected %h", tag, dout2, e2);
      end
    testsRun++;
    assert (error === eErr)
      else begin
        failCount++;
        $error("[TB] FAIL %s error: observed %b expected %b", tag, error, eErr);
      end
  endtask

  // Drives one cycle, advances the model to its post-edge state, then checks.
  task automatic applyStimulus(input string tag, input logic r,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic w1, input logic rd1,
                               input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                               input logic w2, input logic rd2);
    logic act1, act2;
    rst = r;
    addr1 = a1; din1 = d1; wen1 = w1; ren1 = rd1;
    addr2 = a2; din2 = d2; wen2 = w2; ren2 = rd2;
    act1 = w1 | rd1;
    act2 = w2 | rd2;
    if (r) begin
      expDout1 = '0;
      expDout2 = '0;
    end else if (act1) begin
      if (rd1 && !w1) expDout1 = model[a1];
    end else if (act2) begin
      if (rd2 && !w2) expDout2 = model[a2];
    end
    if (act1) begin
      if (w1) model[a1] = d1;
    end else if (act2 && w2) begin
      model[a2] = d2;
    end
    exp1Q.push_back(expDout1);
    exp2Q.push_back(expDout2);
    expErrQ.push_back(!r && act1 && act2);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(tag, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    expDout1 = '0;
    expDout2 = '0;

    // Reset with random traffic kept off address 0 so the post-reset read is clean.
    for (int i = 0; i < 2; i++) begin
      applyStimulus("reset", 1'b1,
                    AW'($urandom_range(1, DEPTH - 1)), DW'($urandom), 1'($urandom), 1'($urandom),
                    AW'($urandom_range(1, DEPTH - 1)), DW'($urandom), 1'($urandom), 1'($urandom));
    end
    applyStimulus("read0", 1'b0, 11'h000, 8'h00, 1'b0, 1'b1, 11'h000, 8'h00, 1'b0, 1'b0);

    applyStimulus("xfer_wr1", 1'b0, 11'h123, 8'hA5, 1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0);
    applyStimulus("xfer_rd2", 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h123, 8'h00, 1'b0, 1'b1);
    idle("xfer_hold", 1);

    applyStimulus("rev_wr2", 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h7FF, 8'h3C, 1'b1, 1'b0);
    applyStimulus("rev_rd1", 1'b0, 11'h7FF, 8'h00, 1'b0, 1'b1, 11'h000, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("rev_hold", 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h7FF, 8'h11, 1'b1, 1'b0);
    end

    applyStimulus("col_pre_wr", 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h010, 8'h99, 1'b1, 1'b0);
    applyStimulus("col_pre_rd", 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h010, 8'h00, 1'b0, 1'b1);
    applyStimulus("col_wr_rd", 1'b0, 11'h010, 8'h55, 1'b1, 1'b0, 11'h010, 8'h00, 1'b0, 1'b1);
    idle("col_clear", 1);
    applyStimulus("col_rdback", 1'b0, 11'h010, 8'h00, 1'b0, 1'b1, 11'h000, 8'h00, 1'b0, 1'b0);

    applyStimulus("col_wr_wr", 1'b0, 11'h020, 8'h01, 1'b1, 1'b0, 11'h020, 8'h02, 1'b1, 1'b0);
    idle("col_ww_clear", 1);
    applyStimulus("col_ww_rd", 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h020, 8'h00, 1'b0, 1'b1);

    applyStimulus("wen_ren", 1'b0, 11'h030, 8'h77, 1'b1, 1'b1, 11'h000, 8'h00, 1'b0, 1'b0);
    applyStimulus("wen_ren_rd", 1'b0, 11'h030, 8'h00, 1'b0, 1'b1, 11'h000, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus("stream_wr", 1'b0, AW'(i), DW'(i), 1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus("stream_rd", 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, AW'(i), 8'h00, 1'b0, 1'b1);
    end

    // Requests during reset: writes land, reads and collisions are masked.
    applyStimulus("rst_wr2", 1'b1, 11'h000, 8'h00, 1'b0, 1'b0, 11'h040, 8'hEE, 1'b1, 1'b0);
    applyStimulus("rst_rd1", 1'b1, 11'h010, 8'h00, 1'b0, 1'b1, 11'h000, 8'h00, 1'b0, 1'b0);
    applyStimulus("rst_col", 1'b1, 11'h010, 8'h00, 1'b0, 1'b1, 11'h020, 8'h00, 1'b0, 1'b1);
    applyStimulus("rst_rdback", 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h040, 8'h00, 1'b0, 1'b1);
    idle("final_idle", 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
